// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the memory port arbiter.
//   mem_owner_t          : which requester issued an outstanding memory transaction
//   DEFAULT_*            : default parameter values for the arbiter
//   cnt_width()          : bits needed to hold a count from 0 to n inclusive
package mem_port_arbiter_pkg;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_LSU   = 1'b1
  } mem_owner_t;

  localparam int DEFAULT_STARVE_LIMIT    = 4;
  localparam int DEFAULT_MAX_OUTSTANDING = 2;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_owner_fifo.sv
// In-order FIFO of transaction owners (1-bit entries).
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   push          : write push_owner at the tail (ignored when full)
//   push_owner    : owner of the transaction being accepted
//   pop           : drop the head entry (ignored when empty)
//   full, empty   : derived from the registered count
//   head          : owner of the oldest outstanding transaction
module owner_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = DEFAULT_MAX_OUTSTANDING
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  mem_owner_t push_owner,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output mem_owner_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = cnt_width(DEPTH);

  mem_owner_t       entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap keeps the pointers legal for any depth, not just 2^PTR_W.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = entries[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset: an entry is only read after it has been pushed.
  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr] <= push_owner;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch (reads) and the
// LSU (loads and byte-masked stores). Owners of accepted transactions are
// kept in order so each response is routed back to its issuer with no added
// latency.
// Ports:
//   clk, reset                       : clock, synchronous active-high reset
//   if_req/if_addr/if_gnt            : fetch request, address, acceptance
//   if_rvalid/if_rdata               : fetch read response
//   lsu_req/lsu_we/lsu_addr/lsu_wdata: LSU request (lsu_we == 0 is a load)
//   lsu_gnt                          : LSU acceptance
//   lsu_rvalid/lsu_rdata             : LSU response (load data or store ack)
//   mem_req/mem_addr/mem_we/mem_wdata: request to memory
//   mem_ready                        : memory accepts mem_req this cycle
//   mem_rvalid/mem_rdata             : in-order memory response
//   resp_error                       : sticky, response with nothing outstanding
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int STARVE_LIMIT    = DEFAULT_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        lsu_req,
  input  logic [3:0]  lsu_we,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_gnt,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        resp_error
);

  localparam int STARVE_W = cnt_width(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt;
  logic                starved;
  mem_owner_t          winner;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  mem_owner_t          fifo_head;

  assign starved = (starve_cnt == STARVE_W'(STARVE_LIMIT));

  // LSU normally wins since it carries the older instruction; a starved
  // fetch overrides that.
  always_comb begin
    winner = OWNER_LSU;
    if (if_req && (!lsu_req || starved)) winner = OWNER_FETCH;
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_addr   = '0;
    mem_we     = '0;
    mem_wdata  = '0;
    if_gnt     = 1'b0;
    lsu_gnt    = 1'b0;
    if_rvalid  = 1'b0;
    if_rdata   = '0;
    lsu_rvalid = 1'b0;
    lsu_rdata  = '0;
    if (!reset) begin
      mem_req = (if_req | lsu_req) & ~fifo_full;
      if (winner == OWNER_FETCH) begin
        mem_addr = if_addr;
      end else begin
        mem_addr  = lsu_addr;
        mem_we    = lsu_we;
        mem_wdata = lsu_wdata;
      end
      if_gnt  = mem_req & mem_ready & (winner == OWNER_FETCH);
      lsu_gnt = mem_req & mem_ready & (winner == OWNER_LSU);
      if (mem_rvalid && !fifo_empty) begin
        if (fifo_head == OWNER_FETCH) begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
        end else begin
          lsu_rvalid = 1'b1;
          lsu_rdata  = mem_rdata;
        end
      end
    end
  end

  assign fifo_pop = mem_rvalid & ~fifo_empty & ~reset;

  owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (if_gnt | lsu_gnt),
    .push_owner (winner),
    .pop        (fifo_pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= '0;
    end else if (lsu_req && lsu_gnt && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_error <= 1'b0;
    end else if (mem_rvalid && fifo_empty) begin
      resp_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int MAX_OUT = 2;
  localparam int LIMIT   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        lsu_req = 1'b0;
  logic [3:0]  lsu_we = '0;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic        lsu_gnt;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        resp_error;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MAX_OUTSTANDING (MAX_OUT),
    .STARVE_LIMIT    (LIMIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .lsu_req    (lsu_req),
    .lsu_we     (lsu_we),
    .lsu_addr   (lsu_addr),
    .lsu_wdata  (lsu_wdata),
    .lsu_gnt    (lsu_gnt),
    .lsu_rvalid (lsu_rvalid),
    .lsu_rdata  (lsu_rdata),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .resp_error (resp_error)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: owners of outstanding transactions, oldest first
  // (0 = fetch, 1 = LSU), how many times in a row fetch has lost, and the
  // sticky error flag.
  int owner_q[$];
  int m_starve = 0;
  bit m_err = 1'b0;
  bit exp_if_gnt_d = 1'b0;
  bit exp_lsu_gnt_d = 1'b0;

  // Inputs change only at posedge+1, so values seen here hold through the
  // next active edge; the model state is advanced to its post-edge value.
  always @(negedge clk) begin
    bit fw, ereq, acc, e_ifv, e_lsv;
    if (reset) begin
      check("rst_mem_req", mem_req, 0);
      check("rst_if_gnt", if_gnt, 0);
      check("rst_lsu_gnt", lsu_gnt, 0);
      check("rst_if_rvalid", if_rvalid, 0);
      check("rst_lsu_rvalid", lsu_rvalid, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_lsu_rdata", lsu_rdata, 0);
      owner_q.delete();
      m_starve = 0;
      m_err = 1'b0;
      exp_if_gnt_d = 1'b0;
      exp_lsu_gnt_d = 1'b0;
    end else begin
      fw   = if_req && (!lsu_req || m_starve >= LIMIT);
      ereq = (if_req || lsu_req) && (owner_q.size() < MAX_OUT);
      acc  = ereq && mem_ready;
      check("mem_req", mem_req, 32'(ereq));
      check("if_gnt", if_gnt, 32'(acc && fw));
      check("lsu_gnt", lsu_gnt, 32'(acc && !fw));
      if (ereq) begin
        check("mem_addr", mem_addr, fw ? if_addr : lsu_addr);
        check("mem_we", mem_we, fw ? 32'h0 : 32'(lsu_we));
        if (!fw) check("mem_wdata", mem_wdata, lsu_wdata);
      end
      e_ifv = mem_rvalid && owner_q.size() > 0 && owner_q[0] == 0;
      e_lsv = mem_rvalid && owner_q.size() > 0 && owner_q[0] == 1;
      check("if_rvalid", if_rvalid, 32'(e_ifv));
      check("lsu_rvalid", lsu_rvalid, 32'(e_lsv));
      if (e_ifv) check("if_rdata", if_rdata, mem_rdata);
      if (e_lsv) check("lsu_rdata", lsu_rdata, mem_rdata);
      check("resp_error", resp_error, 32'(m_err));

      if (mem_rvalid) begin
        if (owner_q.size() > 0) void'(owner_q.pop_front());
        else m_err = 1'b1;
      end
      if (acc) owner_q.push_back(fw ? 0 : 1);
      if (!if_req || (acc && fw)) m_starve = 0;
      else if (lsu_req && acc && !fw && m_starve < LIMIT) m_starve++;
      exp_if_gnt_d = acc && fw;
      exp_lsu_gnt_d = acc && !fw;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0;
    lsu_req = 1'b0;
    lsu_we = '0;
    mem_rvalid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;

    // Fetch alone, memory latency 1.
    if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1;
    @(negedge clk);
    check("t1_if_gnt", if_gnt, 1);
    check("t1_mem_addr", mem_addr, 32'h100);
    check("t1_mem_we", mem_we, 0);
    tick();
    if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("t1_if_rvalid", if_rvalid, 1);
    check("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    check("t1_lsu_rvalid", lsu_rvalid, 0);
    tick();

    // Both request: LSU store wins, its response returns first.
    mem_rvalid = 1'b0;
    if_req = 1'b1; if_addr = 32'h104;
    lsu_req = 1'b1; lsu_we = 4'b0011; lsu_addr = 32'h200; lsu_wdata = 32'h12345678;
    @(negedge clk);
    check("t2_lsu_gnt", lsu_gnt, 1);
    check("t2_if_gnt", if_gnt, 0);
    check("t2_mem_we", mem_we, 4'b0011);
    check("t2_mem_addr", mem_addr, 32'h200);
    tick();
    lsu_req = 1'b0; lsu_we = '0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0A0A;
    @(negedge clk);
    check("t2_lsu_rvalid", lsu_rvalid, 1);
    check("t2_if_rvalid", if_rvalid, 0);
    check("t2_if_gnt_next", if_gnt, 1);
    tick();
    if_req = 1'b0; mem_rdata = 32'h0000_0B0B;
    @(negedge clk);
    check("t2_if_rvalid_late", if_rvalid, 1);
    tick();
    mem_rvalid = 1'b0;

    // Starvation: both requesting continuously, latency-1 memory.
    if_req = 1'b1; if_addr = 32'h300;
    lsu_req = 1'b1; lsu_we = 4'b1111; lsu_addr = 32'h400; lsu_wdata = 32'h5555AAAA;
    for (int i = 0; i < 10; i++) begin
      mem_rvalid = (i > 0);
      mem_rdata = 32'h1000 + 32'(i);
      @(negedge clk);
      check($sformatf("t3_if_gnt_%0d", i), if_gnt, 32'(i % 5 == 4));
      check($sformatf("t3_lsu_gnt_%0d", i), lsu_gnt, 32'(i % 5 != 4));
      tick();
    end
    if_req = 1'b0; lsu_req = 1'b0; lsu_we = '0; mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;

    // Back-pressure: FIFO fills after two grants.
    if_req = 1'b1; if_addr = 32'h500;
    @(negedge clk);
    check("t4_gnt0", if_gnt, 1);
    tick();
    if_req = 1'b0; lsu_req = 1'b1; lsu_addr = 32'h600;
    @(negedge clk);
    check("t4_gnt1", lsu_gnt, 1);
    tick();
    lsu_req = 1'b0; if_req = 1'b1; if_addr = 32'h504;
    @(negedge clk);
    check("t4_full_req", mem_req, 0);
    check("t4_full_gnt", {if_gnt, lsu_gnt}, 0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hA;
    @(negedge clk);
    check("t4_pop_if_rvalid", if_rvalid, 1);
    check("t4_pop_still_blocked", mem_req, 0);
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("t4_resume_gnt", if_gnt, 1);
    tick();
    if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hB;
    @(negedge clk);
    check("t4_second_lsu", lsu_rvalid, 1);
    check("t4_second_lsu_data", lsu_rdata, 32'hB);
    tick();
    mem_rdata = 32'hC;
    @(negedge clk);
    check("t4_third_if", if_rvalid, 1);
    tick();

    // Spurious response with nothing outstanding.
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
    @(negedge clk);
    check("t5_no_if_rvalid", if_rvalid, 0);
    check("t5_no_lsu_rvalid", lsu_rvalid, 0);
    check("t5_err_before", resp_error, 0);
    tick();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("t5_err_set", resp_error, 1);
    tick();
    tick();

    // Reset with two transactions outstanding.
    if_req = 1'b1; if_addr = 32'h700;
    @(negedge clk);
    check("t6_err_sticky", resp_error, 1);
    tick();
    tick();
    reset = 1'b1; lsu_req = 1'b1; mem_rvalid = 1'b1;
    @(negedge clk);
    check("t6_rst_gnts", {if_gnt, lsu_gnt}, 0);
    check("t6_rst_rvalids", {if_rvalid, lsu_rvalid}, 0);
    tick();
    reset = 1'b0; lsu_req = 1'b0; mem_rvalid = 1'b0; if_addr = 32'h300;
    @(negedge clk);
    check("t6_post_gnt", if_gnt, 1);
    check("t6_post_err", resp_error, 0);
    tick();
    if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check("t6_post_if_rvalid", if_rvalid, 1);
    check("t6_post_if_rdata", if_rdata, 32'hCAFEF00D);
    tick();
    idle_inputs();

    // Random traffic; requesters hold until granted, memory answers only
    // what is outstanding except for rare spurious responses.
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset = ($urandom_range(0, 199) == 0);
      if (!(if_req && !exp_if_gnt_d)) begin
        if_req = ($urandom_range(0, 2) != 0);
        if_addr = $urandom;
      end
      if (!(lsu_req && !exp_lsu_gnt_d)) begin
        lsu_req = ($urandom_range(0, 2) != 0);
        lsu_addr = $urandom;
        lsu_wdata = $urandom;
        lsu_we = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      if (owner_q.size() > 0) mem_rvalid = $urandom_range(0, 1);
      else mem_rvalid = ($urandom_range(0, 49) == 0);
      mem_rdata = $urandom;
    end
    tick();
    reset = 1'b0;
    idle_inputs();
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data/instruction memory between instruction fetch (read-only) and the execute-stage load/store unit (reads and byte-masked writes).
- Arbitrates requests and tracks outstanding transactions in an in-order owner FIFO.
- Routes each memory response back to the requester that issued it.
- Withholds grants to throttle requesters: fetch and execute hold their request while their grant is low.

Parameters:
- MAX_OUTSTANDING, 2, depth of the owner FIFO; maximum accepted-but-unanswered memory transactions (power of two, >= 1).
- STARVE_LIMIT, 4, consecutive cycles fetch may request and lose to LSU before fetch is forced to win.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- if_req  in  1  fetch read request.
- if_addr  in  32  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  32  fetch read data.
- lsu_req  in  1  LSU request (load or store).
- lsu_we  in  4  byte write enables; 0 = load.
- lsu_addr  in  32  LSU address.
- lsu_wdata  in  32  store data.
- lsu_gnt  out  1  LSU request accepted this cycle.
- lsu_rvalid  out  1  LSU response valid (load data or store acknowledge).
- lsu_rdata  out  32  load data.
- mem_req  out  1  memory request.
- mem_addr  out  32  memory address.
- mem_we  out  4  memory byte write enables.
- mem_wdata  out  32  memory write data.
- mem_ready  in  1  memory accepts mem_req this cycle.
- mem_rvalid  in  1  memory response, one per accepted request, in order.
- mem_rdata  in  32  memory read data.
- resp_error  out  1  sticky: a response arrived with no outstanding transaction.

Behaviour:
- Winner selection (combinational):
  - Default priority is LSU over fetch, because LSU carries the older instruction.
  - If starve_cnt == STARVE_LIMIT and if_req is high, fetch wins.
- Request issue:
  - mem_req = (if_req | lsu_req) & !fifo_full.
  - mem_addr, mem_we and mem_wdata come from the winner; mem_we = 0 when fetch wins.
- Grants:
  - if_gnt / lsu_gnt = mem_req & mem_ready & (winner is that requester).
  - At most one grant per cycle.
  - The loser sees gnt = 0 and must hold its request stable.
- Acceptance (mem_req & mem_ready): push the winner ID (0 = fetch, 1 = LSU) into the owner FIFO in the same clock edge.
- Response routing:
  - On mem_rvalid, pop the FIFO head and route that cycle, combinationally.
  - Head = fetch: if_rvalid = 1, if_rdata = mem_rdata.
  - Head = LSU: lsu_rvalid = 1, lsu_rdata = mem_rdata.
  - Response latency is whatever the memory provides; the arbiter adds 0 cycles.
- Push and pop in the same cycle: count unchanged, both operations take effect. A full FIFO with a simultaneous pop still blocks the push, because fifo_full is evaluated on the registered count.
- fifo_full (count == MAX_OUTSTANDING) forces mem_req = 0 and both gnts = 0.
- mem_rvalid while the FIFO is empty:
  - Response is dropped; neither rvalid asserts.
  - resp_error sets and stays set until reset.
- Starvation counter:
  - Increments when if_req & lsu_req & lsu_gnt, saturating at STARVE_LIMIT.
  - Clears when if_gnt = 1, or when if_req = 0.
- Pointer wrap: read and write pointers wrap modulo MAX_OUTSTANDING; count width is clog2(MAX_OUTSTANDING)+1.
- Reset (synchronous, any cycle including mid-transaction):
  - FIFO pointers, count, starve_cnt and resp_error go to 0.
  - While reset is high, mem_req, if_gnt, lsu_gnt, if_rvalid and lsu_rvalid are forced to 0; data outputs are 0.
  - The system quiesces memory across reset. Stale responses after reset hit an empty FIFO and set resp_error.
- No internal state machine beyond the FIFO and counter.

Decomposition:
- Shared package gains:
  - typedef enum logic {OWNER_FETCH, OWNER_LSU} mem_owner_t.
  - Constant DEFAULT_STARVE_LIMIT.
- One natural sub-module: owner_fifo.
  - Parameterized depth, 1-bit entries.
  - push/pop/full/empty/head; synchronous active-high reset.

Test Plan:
1. Fetch only: if_req = 1, mem_ready = 1, memory latency 1, address 0x100, data 0xDEADBEEF -> if_gnt the same cycle; if_rvalid = 1 with 0xDEADBEEF one cycle later; lsu_rvalid stays 0.
2. Simultaneous if_req and lsu_req (store, lsu_we = 4'b0011, address 0x200) -> lsu_gnt = 1, mem_we = 4'b0011, if_gnt = 0; the next response goes to lsu_rvalid.
3. Starvation: both requesting every cycle with STARVE_LIMIT = 4 -> LSU granted 4 cycles, fetch granted on the 5th, starve_cnt back to 0.
4. Back-pressure: mem_ready = 1, mem_rvalid held 0, alternating requesters -> 2 grants, then mem_req = 0 and both gnts = 0. A single mem_rvalid frees one slot; grant resumes the following cycle. The two responses route to the owners in issue order.
5. Spurious response: mem_rvalid = 1 with the FIFO empty -> no rvalid asserted; resp_error = 1 from the next cycle, persisting until reset.
6. Reset mid-operation: 2 outstanding, assert reset for 1 cycle -> all grants and rvalids 0 during reset; count = 0 after. The first new fetch request is granted and its response routes to fetch.
